// File: rtl/noc_injector.sv
// NoC injection port: queues packets offered by a processing element and
// writes them into the attached switch's resource-port input FIFO.
// Packets addressed outside the mesh are dropped and counted.
module noc_injector #(
  parameter int unsigned COL_CORD        = 0,
  parameter int unsigned ROW_CORD        = 0,
  parameter int unsigned COL_N           = 4,
  parameter int unsigned ROW_N           = 4,
  parameter int unsigned FIFO_DEPTH_W    = 2,
  parameter int unsigned PCKT_COL_ADDR_W = 4,
  parameter int unsigned PCKT_ROW_ADDR_W = 4,
  parameter int unsigned PCKT_DATA_W     = 8,
  parameter int unsigned PCKT_W          = PCKT_COL_ADDR_W + PCKT_ROW_ADDR_W + PCKT_DATA_W,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [PCKT_COL_ADDR_W-1:0] dst_col_i,
  input  logic [PCKT_ROW_ADDR_W-1:0] dst_row_i,
  input  logic [PCKT_DATA_W-1:0]     data_i,
  output logic                       wr_en_o,
  output logic [PCKT_W-1:0]          pckt_o,
  input  logic                       nxt_fifo_full_i,
  input  logic                       nxt_fifo_overflow_i,
  output logic                       drop_o,
  output logic                       err_o,
  output logic [CNT_W-1:0]           sent_cnt_o,
  output logic [CNT_W-1:0]           drop_cnt_o
);

  localparam int unsigned Depth = 2 ** FIFO_DEPTH_W;
  localparam logic [FIFO_DEPTH_W:0] DepthCnt = (FIFO_DEPTH_W + 1)'(Depth);

  typedef enum logic [1:0] {StEmpty, StActive, StFull} state_e;

  state_e                  state_q, state_d;
  logic [FIFO_DEPTH_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_W:0]   count_q, count_d;
  logic [PCKT_W-1:0]       mem_q [Depth];
  logic                    err_q, drop_q;
  logic [CNT_W-1:0]        sent_cnt_q, drop_cnt_q;

  logic xfer, in_range, push, pop, drop;
  logic [PCKT_W-1:0] pckt_in;

  // The switch resolves local delivery, so the own coordinates never gate
  // injection; they are kept only as configuration of the attachment point.
  logic unused_coords;
  assign unused_coords = ^{32'(COL_CORD), 32'(ROW_CORD)};

  // Handshake and packet assembly; ready and write strobe come from state only.
  always_comb begin
    ready_o  = (state_q != StFull);
    wr_en_o  = (state_q != StEmpty) && !nxt_fifo_full_i;
    pckt_o   = (state_q == StEmpty) ? '0 : mem_q[rd_ptr_q];
    xfer     = valid_i && ready_o;
    in_range = (32'(dst_col_i) < COL_N) && (32'(dst_row_i) < ROW_N);
    push     = xfer && in_range;
    drop     = xfer && !in_range;
    pop      = wr_en_o;
    pckt_in  = {dst_col_i, dst_row_i, data_i};
  end

  // Occupancy and state next-state; push and pop together leave count as is.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (count_d == '0) begin
      state_d = StEmpty;
    end else if (count_d == DepthCnt) begin
      state_d = StFull;
    end else begin
      state_d = StActive;
    end
  end

  // Queue storage; contents need no reset since the head is masked when empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pckt_in;
    end
  end

  // Pointers, count, state, status flags and statistics counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StEmpty;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      sent_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      drop_q  <= drop;
      err_q   <= err_q | nxt_fifo_overflow_i;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        sent_cnt_q <= sent_cnt_q + 1'b1;
      end
      if (drop) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign drop_o     = drop_q;
  assign err_o      = err_q;
  assign sent_cnt_o = sent_cnt_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_noc_injector.sv
// Self-checking bench for noc_injector: scoreboard of expected packets,
// filled when stimulus is driven and drained on each observed write.
module tb_noc_injector;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [3:0]  dst_col_i = '0;
  logic [3:0]  dst_row_i = '0;
  logic [7:0]  data_i = '0;
  logic        wr_en_o;
  logic [15:0] pckt_o;
  logic        nxt_fifo_full_i = 1'b0;
  logic        nxt_fifo_overflow_i = 1'b0;
  logic        drop_o;
  logic        err_o;
  logic [15:0] sent_cnt_o;
  logic [15:0] drop_cnt_o;

  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  logic [15:0] exp_q [$];

  noc_injector dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .valid_i            (valid_i),
    .ready_o            (ready_o),
    .dst_col_i          (dst_col_i),
    .dst_row_i          (dst_row_i),
    .data_i             (data_i),
    .wr_en_o            (wr_en_o),
    .pckt_o             (pckt_o),
    .nxt_fifo_full_i    (nxt_fifo_full_i),
    .nxt_fifo_overflow_i(nxt_fifo_overflow_i),
    .drop_o             (drop_o),
    .err_o              (err_o),
    .sent_cnt_o         (sent_cnt_o),
    .drop_cnt_o         (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every write must match the oldest expected packet.
  always @(negedge clk_i) begin
    if (rst_ni && wr_en_o) begin
      n_wr++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got pckt %h, expected no write", pckt_o);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (pckt_o !== e) begin
          errors++;
          $display("FAIL write_order: got pckt %h, expected %h", pckt_o, e);
        end
      end
    end
  end

  // Offer one packet for one cycle; called and returns at posedge+1.
  task automatic send(input logic [3:0] col, input logic [3:0] row, input logic [7:0] data);
    valid_i   = 1'b1;
    dst_col_i = col;
    dst_row_i = row;
    data_i    = data;
    @(negedge clk_i);
    if (ready_o === 1'b1 && col < 4 && row < 4) exp_q.push_back({col, row, data});
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks += 7;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, expected 1", ready_o); end
    if (wr_en_o !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b, expected 0", wr_en_o); end
    if (pckt_o !== 16'h0) begin errors++; $display("FAIL rst_pckt: got %h, expected 0", pckt_o); end
    if (drop_o !== 1'b0) begin errors++; $display("FAIL rst_drop: got %b, expected 0", drop_o); end
    if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, expected 0", err_o); end
    if (sent_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_sent: got %0d, expected 0", sent_cnt_o); end
    if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_dropcnt: got %0d, expected 0", drop_cnt_o); end
    #3 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_single();
    send(4'd1, 4'd2, 8'hA5);
    @(negedge clk_i);
    checks += 2;
    if (wr_en_o !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %b, expected 1", wr_en_o); end
    if (pckt_o !== 16'h12A5) begin errors++; $display("FAIL single_pckt: got %h, expected 12a5", pckt_o); end
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    checks += 2;
    if (sent_cnt_o !== 16'd1) begin errors++; $display("FAIL single_sent: got %0d, expected 1", sent_cnt_o); end
    if (wr_en_o !== 1'b0) begin errors++; $display("FAIL single_idle: got %b, expected 0", wr_en_o); end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_backpressure();
    nxt_fifo_full_i = 1'b1;
    for (int k = 0; k < 4; k++) send(4'(k), 4'(3 - k), 8'(8'h40 + k));
    @(negedge clk_i);
    checks += 3;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b, expected 0", ready_o); end
    if (wr_en_o !== 1'b0) begin errors++; $display("FAIL bp_wr_en: got %b, expected 0", wr_en_o); end
    if (pckt_o !== 16'h0340) begin errors++; $display("FAIL bp_head: got %h, expected 0340", pckt_o); end
    @(posedge clk_i);
    #1;
    send(4'd2, 4'd2, 8'hEE);  // refused: queue full
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      checks++;
      if (wr_en_o !== 1'b0) begin errors++; $display("FAIL bp_stall: got %b, expected 0", wr_en_o); end
      @(posedge clk_i);
      #1;
    end
    nxt_fifo_full_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      checks++;
      if (wr_en_o !== 1'b1) begin errors++; $display("FAIL bp_drain%0d: got %b, expected 1", k, wr_en_o); end
      @(posedge clk_i);
      #1;
    end
    @(negedge clk_i);
    checks += 4;
    if (wr_en_o !== 1'b0) begin errors++; $display("FAIL bp_done: got %b, expected 0", wr_en_o); end
    if (sent_cnt_o !== 16'd5) begin errors++; $display("FAIL bp_sent: got %0d, expected 5", sent_cnt_o); end
    if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b, expected 1", ready_o); end
    if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL bp_nodrop: got %0d, expected 0", drop_cnt_o); end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_drop();
    int wr0;
    wr0 = n_wr;
    send(4'd4, 4'd0, 8'h77);
    @(negedge clk_i);
    checks += 3;
    if (drop_o !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b, expected 1", drop_o); end
    if (drop_cnt_o !== 16'd1) begin errors++; $display("FAIL drop_cnt1: got %0d, expected 1", drop_cnt_o); end
    if (wr_en_o !== 1'b0) begin errors++; $display("FAIL drop_wr_en: got %b, expected 0", wr_en_o); end
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    checks++;
    if (drop_o !== 1'b0) begin errors++; $display("FAIL drop_once: got %b, expected 0", drop_o); end
    @(posedge clk_i);
    #1;
    send(4'd0, 4'd4, 8'h78);
    @(negedge clk_i);
    checks += 2;
    if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL drop_cnt2: got %0d, expected 2", drop_cnt_o); end
    if (n_wr !== wr0) begin errors++; $display("FAIL drop_nowrite: got %0d writes, expected %0d", n_wr, wr0); end
    @(posedge clk_i);
    #1;
    send(4'd0, 4'd0, 8'h33);  // own coordinates still injected
    send(4'd3, 4'd3, 8'hCC);  // highest in-range address
    repeat (3) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    checks += 3;
    if (exp_q.size() != 0) begin errors++; $display("FAIL edge_addr_drain: got %0d pending, expected 0", exp_q.size()); end
    if (sent_cnt_o !== 16'd7) begin errors++; $display("FAIL edge_addr_sent: got %0d, expected 7", sent_cnt_o); end
    if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL edge_addr_dropcnt: got %0d, expected 2", drop_cnt_o); end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_overflow();
    nxt_fifo_overflow_i = 1'b1;
    @(posedge clk_i);
    #1;
    nxt_fifo_overflow_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, expected 1", err_o); end
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, expected 1", err_o); end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset_mid();
    int wr0;
    nxt_fifo_full_i = 1'b1;
    for (int k = 0; k < 3; k++) send(4'(k + 1), 4'(k), 8'(8'h90 + k));
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    checks += 7;
    if (wr_en_o !== 1'b0) begin errors++; $display("FAIL mid_wr_en: got %b, expected 0", wr_en_o); end
    if (ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b, expected 1", ready_o); end
    if (pckt_o !== 16'h0) begin errors++; $display("FAIL mid_pckt: got %h, expected 0", pckt_o); end
    if (sent_cnt_o !== 16'd0) begin errors++; $display("FAIL mid_sent: got %0d, expected 0", sent_cnt_o); end
    if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL mid_dropcnt: got %0d, expected 0", drop_cnt_o); end
    if (err_o !== 1'b0) begin errors++; $display("FAIL mid_err: got %b, expected 0", err_o); end
    if (drop_o !== 1'b0) begin errors++; $display("FAIL mid_drop: got %b, expected 0", drop_o); end
    exp_q.delete();
    nxt_fifo_full_i = 1'b0;
    @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    wr0 = n_wr;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      checks++;
      if (wr_en_o !== 1'b0) begin errors++; $display("FAIL mid_stale: got %b, expected 0", wr_en_o); end
      @(posedge clk_i);
      #1;
    end
    checks++;
    if (n_wr !== wr0) begin errors++; $display("FAIL mid_nowrite: got %0d writes, expected %0d", n_wr, wr0); end
  endtask

  task automatic test_stream();
    bit drained;
    for (int i = 0; i < 100; i++) begin
      valid_i   = 1'b1;
      dst_col_i = 4'(i % 4);
      dst_row_i = 4'((i / 4) % 4);
      data_i    = 8'(i);
      @(negedge clk_i);
      checks++;
      if (ready_o !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready%0d: got %b, expected 1", i, ready_o);
      end else begin
        exp_q.push_back({dst_col_i, dst_row_i, data_i});
      end
      if (i > 0) begin
        checks++;
        if (wr_en_o !== 1'b1) begin errors++; $display("FAIL stream_rate%0d: got %b, expected 1", i, wr_en_o); end
      end
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b0;
    drained = 1'b0;
    for (int k = 0; k < 10 && !drained; k++) begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() == 0) drained = 1'b1;
    end
    checks++;
    if (!drained) begin errors++; $display("FAIL stream_drain: got %0d pending, expected 0", exp_q.size()); end
    @(negedge clk_i);
    checks += 2;
    if (sent_cnt_o !== 16'd100) begin errors++; $display("FAIL stream_sent: got %0d, expected 100", sent_cnt_o); end
    if (wr_en_o !== 1'b0) begin errors++; $display("FAIL stream_idle: got %b, expected 0", wr_en_o); end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_drop();
    test_overflow();
    test_reset_mid();
    test_stream();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: got %0d pending, expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_injector.md
NOC_INJECTOR -- requirements
Module: noc_injector

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- COL_CORD, 0, column of the attached switch
- ROW_CORD, 0, row of the attached switch
- COL_N, 4, mesh columns
- ROW_N, 4, mesh rows
- FIFO_DEPTH_W, 2, log2 of injection queue depth
- PCKT_COL_ADDR_W, 4
- PCKT_ROW_ADDR_W, 4
- PCKT_DATA_W, 8
- PCKT_W, sum of the three widths above
- CNT_W, 16, width of the statistics counters
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, the single clock
- rst_ni, in, 1, reset; asynchronous, active-low
- valid_i, in, 1, PE offers a packet
- ready_o, out, 1, injector can accept
- dst_col_i, in, PCKT_COL_ADDR_W, destination column
- dst_row_i, in, PCKT_ROW_ADDR_W, destination row
- data_i, in, PCKT_DATA_W, payload
- wr_en_o, out, 1, write strobe into the switch resource-port input FIFO
- pckt_o, out, PCKT_W, packet to the switch
- nxt_fifo_full_i, in, 1, switch resource FIFO full
- nxt_fifo_overflow_i, in, 1, switch resource FIFO overflow
- drop_o, out, 1, one-cycle pulse when an offered packet is dropped
- err_o, out, 1, sticky overflow error
- sent_cnt_o, out, CNT_W, packets injected
- drop_cnt_o, out, CNT_W, packets dropped

Function
REQ-003 The packet format SHALL be {dst_col[PCKT_W-1 -: PCKT_COL_ADDR_W], dst_row, data[PCKT_DATA_W-1:0]}.
REQ-004 The queue SHALL be a synchronous FIFO of 2**FIFO_DEPTH_W entries, with a count register FIFO_DEPTH_W+1 bits wide and read/write pointers that wrap modulo depth.
REQ-005 ready_o SHALL equal (queue not full) and SHALL NOT depend on valid_i or on a same-cycle pop.
REQ-006 A transfer SHALL occur on a rising edge where valid_i && ready_o.
REQ-007 A transferred packet with dst_col_i >= COL_N or dst_row_i >= ROW_N SHALL NOT be queued; drop_o SHALL pulse high for the following cycle and drop_cnt_o SHALL increment.
REQ-008 All other transferred packets SHALL be pushed, including packets addressed to (COL_CORD, ROW_CORD), since the switch resolves local delivery.
REQ-009 wr_en_o SHALL be combinational: (queue not empty) && !nxt_fifo_full_i.
REQ-010 pckt_o SHALL always present the queue head, and SHALL be 0 when the queue is empty.
REQ-011 Each cycle with wr_en_o high SHALL pop one entry and increment sent_cnt_o.
REQ-012 Latency: a packet accepted at edge N into an empty queue SHALL have wr_en_o high during cycle N+1 if nxt_fifo_full_i is low.
REQ-013 A push and a pop in the same cycle SHALL leave the count unchanged and SHALL preserve order.
REQ-014 A push into an empty queue with a simultaneous pop is impossible by construction (no bypass path).
REQ-015 While nxt_fifo_full_i is high, the queue SHALL hold its contents and wr_en_o SHALL stay low, for any stall length.
REQ-016 err_o SHALL set on any edge where nxt_fifo_overflow_i is high and SHALL stay set until reset.
REQ-017 sent_cnt_o and drop_cnt_o SHALL wrap from 2**CNT_W-1 to 0 without saturating.
REQ-018 A state register SHALL track EMPTY, ACTIVE and FULL (count 0, between, and depth) and SHALL be consistent with ready_o and wr_en_o.

Reset
REQ-019 While rst_ni is low, the block SHALL take its reset values immediately, independent of clk_i: pointers, count, err_o, drop_o and counters at 0; state EMPTY; ready_o=1; wr_en_o=0; pckt_o=0.
REQ-020 A reset asserted mid-operation SHALL flush all queued packets, and no write SHALL be issued after deassertion until a new push occurs.

Verification
REQ-021 Single packet: push col=1, row=2, data=0xA5, with full_i=0 -> next cycle wr_en_o=1, pckt_o=0x12A5, sent_cnt_o=1.
REQ-022 Backpressure: hold full_i=1 and push 4 packets (depth 4) -> ready_o=0 after the 4th push and wr_en_o=0; release full_i -> 4 consecutive wr_en_o pulses in push order.
REQ-023 Out-of-range: push col=4 with COL_N=4 -> drop_o pulses once, drop_cnt_o=1, wr_en_o is never asserted.
REQ-024 Overflow: pulse nxt_fifo_overflow_i for 1 cycle -> err_o=1 and stays 1 until rst_ni goes low.
REQ-025 Reset mid-stream: with 3 packets queued, assert rst_ni low between clock edges -> wr_en_o=0, ready_o=1 and counters at 0 immediately, with no stale packet after release.
REQ-026 Streaming: valid_i held high for 100 cycles with full_i=0 -> 1 packet per cycle after the first cycle, and sent_cnt_o=100 once the queue drains.
